// File: rtl/rf_wport_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rf_wport_arbiter
//  Purpose  : Arbitrates the single register-file write port between
//             in-order write-back retirements and a 2-entry FIFO of
//             long-latency aux results. WB has priority; a starvation
//             counter forces one aux slot after STARVE_LIMIT pass-overs.
//  Revision : 1.0  initial release
// ============================================================================
module rf_wport_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  input  logic [31:0] wb_pc,
  input  logic        aux_valid,
  output logic        aux_ready,
  input  logic [4:0]  aux_waddr,
  input  logic [31:0] aux_wdata,
  input  logic [31:0] aux_pc,
  output logic [37:0] rf_wport,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    ST_NORMAL    = 1'b0,
    ST_FORCE_AUX = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  // FIFO entry layout: {waddr[68:64], wdata[63:32], pc[31:0]}
  logic [68:0] r_mem [2];
  logic [1:0]  r_count;
  logic        r_rd_ptr;
  logic        r_wr_ptr;

  logic [3:0]  r_starve;
  logic [3:0]  w_starve_next;

  logic        w_force;
  logic        w_fifo_nonempty;
  logic        w_push;
  logic        w_grant_wb;
  logic        w_grant_aux;
  logic [68:0] w_head;

  logic        r_we;
  logic [4:0]  r_waddr;
  logic [31:0] r_wdata;
  logic [31:0] r_pc;

  // Both ready signals come from registered state only.
  assign w_force         = (r_state == ST_FORCE_AUX);
  assign w_fifo_nonempty = (r_count != 2'd0);
  assign aux_ready       = (r_count != 2'd2);
  assign wb_ready        = ~w_force;
  assign w_push          = aux_valid & aux_ready;
  assign w_head          = r_mem[r_rd_ptr];

  // Grant mux: a forced slot always goes to aux; otherwise WB first.
  assign w_grant_wb  = wb_valid & ~w_force;
  assign w_grant_aux = w_fifo_nonempty & (w_force | ~wb_valid);

  // Starvation counter next value and FSM next state.
  always_comb begin
    w_starve_next = r_starve;
    w_state_next  = ST_NORMAL;
    if (!w_fifo_nonempty || w_grant_aux) begin
      w_starve_next = 4'd0;
    end else if (r_starve != C_LIMIT) begin
      w_starve_next = r_starve + 4'd1;
    end
    // The forced slot is the cycle in which the counter reads STARVE_LIMIT;
    // a counter that only grows while nothing is popped implies a
    // non-empty FIFO in that cycle.
    if ((r_state == ST_NORMAL) && (w_starve_next == C_LIMIT) && w_fifo_nonempty) begin
      w_state_next = ST_FORCE_AUX;
    end
  end

  // FSM state and starvation counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_NORMAL;
      r_starve <= 4'd0;
    end else begin
      r_state  <= w_state_next;
      r_starve <= w_starve_next;
    end
  end

  // FIFO occupancy and pointers; simultaneous push and pop keep the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_grant_aux) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_grant_aux})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; pointer reset makes stale contents unreachable.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {aux_waddr, aux_wdata, aux_pc};
    end
  end

  // Output register: load the winner, or drop the write enable when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_waddr <= 5'd0;
      r_wdata <= 32'd0;
      r_pc    <= 32'd0;
    end else if (w_grant_wb) begin
      r_we    <= wb_we & (wb_waddr != 5'd0);
      r_waddr <= wb_waddr;
      r_wdata <= wb_wdata;
      r_pc    <= wb_pc;
    end else if (w_grant_aux) begin
      r_we    <= (w_head[68:64] != 5'd0);
      r_waddr <= w_head[68:64];
      r_wdata <= w_head[63:32];
      r_pc    <= w_head[31:0];
    end else begin
      r_we    <= 1'b0;
    end
  end

  assign rf_wport          = {r_we, r_waddr, r_wdata};
  assign debug_wb_pc       = r_pc;
  assign debug_wb_rf_we    = {4{r_we}};
  assign debug_wb_rf_wnum  = r_waddr;
  assign debug_wb_rf_wdata = r_wdata;

endmodule
`default_nettype wire
